fir_sample_feeder: RTL

//  Avalon-MM write-side sample buffer placed directly upstream of FIR_transposed.
//  The host pushes 16-bit samples into an internal FIFO over the Avalon slave.
//  On each enable strobe, while RUN is set, the block pops one sample and

---
 rtl/fir_sample_feeder_if.sv | 22 ++
 rtl/fir_sample_feeder.sv | 110 +++++++++++
 2 files changed

// File: rtl/fir_sample_feeder_if.sv
// Host bus and FIR-side sample port for fir_sample_feeder.
// The slave side is the feeder; the master side is the host/test driver.
interface fir_sample_feeder_if #(parameter int DATA_W = 16);
  logic              write;
  logic              read;
  logic [17:0]       address;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              enable;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;

  modport slave (
    input  write, read, address, writedata, enable,
    output readdata, sample_out, sample_valid
  );

  modport master (
    output write, read, address, writedata, enable,
    input  readdata, sample_out, sample_valid
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Avalon-MM sample FIFO feeding FIR_transposed: host pushes samples, each
// enable strobe (while RUN) pops one sample to the FIR input.
module fir_sample_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5
) (
  input  logic clk,
  input  logic reset,
  fir_sample_feeder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [15:0]       count;
  logic              run, ovf, unf;

  logic [1:0]  addr;
  logic        data_wr, ctrl_wr, stat_wr, flush;
  logic        empty, full, pop_try, pop, push_ok, ovf_set, unf_set;
  logic [15:0] status, rd_mux;
  logic        unused_addr_bits;

  assign addr    = bus.address[1:0];
  assign data_wr = bus.write && (addr == 2'd0);
  assign ctrl_wr = bus.write && (addr == 2'd1);
  assign stat_wr = bus.write && (addr == 2'd2);
  assign flush   = ctrl_wr && bus.writedata[1];

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop_try = bus.enable && run;
  // Flush overrides the pop; an empty FIFO never pops even with a same-cycle push.
  assign pop     = pop_try && !empty && !flush;
  assign unf_set = pop_try && empty && !flush;
  // A push into a full FIFO is only safe if the head leaves on the same edge.
  assign push_ok = data_wr && (!full || pop);
  assign ovf_set = data_wr && full && !pop;

  assign unused_addr_bits = ^bus.address[17:2];

  always_comb begin
    status              = '0;
    status[15]          = ovf;
    status[14]          = unf;
    status[13]          = full;
    status[12]          = empty;
    status[LVL_W-1:0]   = level;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd1:    rd_mux = {15'b0, run};
      2'd2:    rd_mux = status;
      2'd3:    rd_mux = count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      count            <= '0;
      run              <= 1'b0;
      ovf              <= 1'b0;
      unf              <= 1'b0;
      bus.readdata     <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      if (bus.read) bus.readdata <= rd_mux;
      if (ctrl_wr)  run <= bus.writedata[0];

      // Sticky set beats a same-cycle write-1-to-clear.
      ovf <= ovf_set | (ovf & ~(stat_wr & bus.writedata[15]));
      unf <= unf_set | (unf & ~(stat_wr & bus.writedata[14]));

      bus.sample_valid <= pop;
      if (pop)          bus.sample_out <= mem[rd_ptr];
      else if (unf_set) bus.sample_out <= '0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= count + 16'd1;
        end
        case ({push_ok, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
    end
  end
endmodule
